// File: rtl/game_ctrl.sv
// game_ctrl: top-level sequencer for the brick game.
// Converts raw pushbuttons into start/aim/launch/pause actions, tracks lives
// and level, and drives the ball engine's state/angle/period/level inputs.
// Optional build macro GAME_CTRL_DEBOUNCE_EN adds a per-button debounce stage
// (parameter DEB_CYCLES exists only in that build).
//
// state | meaning
// ------+--------------------------------------------------
//   0   | IDLE  : waiting for start
//   1   | LOAD  : two-cycle brick/period load for the level
//   2   | AIM   : ball parked, aim with left/right, launch
//   3   | RUN   : ball in play
//   4   | PAUSE : engine frozen, launch resumes, start aborts
//   5   | LOST  : ball lost, dwell then re-aim
//   6   | CLEAR : level cleared, dwell then next level/over
//   7   | OVER  : game finished, game_result valid
module game_ctrl #(
  parameter int LIVES        = 3,
  parameter int NUM_LEVELS   = 3,
  parameter int PERIOD_BASE  = 200000,
  parameter int PERIOD_STEP  = 40000,
  parameter int PAUSE_CYCLES = 50000000
`ifdef GAME_CTRL_DEBOUNCE_EN
  ,
  parameter int DEB_CYCLES   = 500000
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        btn_launch,
  input  logic        btn_aim_l,
  input  logic        btn_aim_r,
  input  logic        dead,
  input  logic        win,
  output logic [2:0]  state,
  output logic [2:0]  angle,
  output logic [19:0] period,
  output logic [2:0]  level,
  output logic [1:0]  lives,
  output logic        game_result
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_AIM   = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_PAUSE = 3'd4;
  localparam logic [2:0] S_LOST  = 3'd5;
  localparam logic [2:0] S_CLEAR = 3'd6;
  localparam logic [2:0] S_OVER  = 3'd7;

  localparam int TW = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST     = TW'(PAUSE_CYCLES - 1);
  localparam logic [19:0]   P_BASE     = 20'(PERIOD_BASE);
  localparam logic [19:0]   P_STEP     = 20'(PERIOD_STEP);
  localparam logic [1:0]    LIVES_INIT = 2'(LIVES);
  localparam logic [2:0]    LAST_LVL   = 3'(NUM_LEVELS - 1);
  localparam logic [2:0]    ANGLE_MID  = 3'd3;
  localparam logic [2:0]    ANGLE_MAX  = 3'd5;

  // bit order: 0 start, 1 launch, 2 aim_l, 3 aim_r
  logic [3:0] btn_raw, sync1, sync2, btn_lvl, btn_prev, press;
  logic       start_p, launch_p, aim_l_p, aim_r_p;
  logic [TW-1:0] timer;
  logic          load_ph;

  assign btn_raw = {btn_aim_r, btn_aim_l, btn_launch, btn_start};

  // two-flop synchronizer for all buttons
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

`ifdef GAME_CTRL_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  logic [3:0]    deb;
  logic [DW-1:0] deb_cnt [4];

  // debounced level follows the synced input only after a stable run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb <= '0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign btn_lvl = deb;
`else
  assign btn_lvl = sync2;
`endif

  // previous-value flop for rising-edge press detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) btn_prev <= '0;
    else     btn_prev <= btn_lvl;
  end

  assign press    = btn_lvl & ~btn_prev;
  assign start_p  = press[0];
  assign launch_p = press[1];
  assign aim_l_p  = press[2];
  assign aim_r_p  = press[3];

  function automatic logic [19:0] period_for(input logic [2:0] lvl);
    return P_BASE - (20'(lvl) * P_STEP);
  endfunction

  // game sequencer; unused presses in a state are simply dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      angle       <= ANGLE_MID;
      level       <= '0;
      lives       <= LIVES_INIT;
      period      <= P_BASE;
      game_result <= 1'b0;
      timer       <= '0;
      load_ph     <= 1'b0;
    end else begin
      timer <= '0;
      case (state)
        S_IDLE, S_OVER: begin
          if (start_p) begin
            state       <= S_LOAD;
            level       <= '0;
            lives       <= LIVES_INIT;
            game_result <= 1'b0;
            period      <= P_BASE;
            load_ph     <= 1'b0;
          end
        end
        S_LOAD: begin
          if (load_ph) begin
            state   <= S_AIM;
            angle   <= ANGLE_MID;
            load_ph <= 1'b0;
          end else begin
            load_ph <= 1'b1;
          end
        end
        S_AIM: begin
          if (aim_l_p && !aim_r_p && angle != 3'd0)
            angle <= angle - 3'd1;
          else if (aim_r_p && !aim_l_p && angle != ANGLE_MAX)
            angle <= angle + 3'd1;
          if (launch_p) state <= S_RUN;
        end
        S_RUN: begin
          if (win) begin
            state <= S_CLEAR;
          end else if (dead) begin
            if (lives > 2'd1) begin
              lives <= lives - 2'd1;
              state <= S_LOST;
            end else begin
              lives       <= 2'd0;
              game_result <= 1'b0;
              state       <= S_OVER;
            end
          end else if (launch_p) begin
            state <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (launch_p)     state <= S_RUN;
          else if (start_p) state <= S_IDLE;
        end
        S_LOST: begin
          if (timer == T_LAST) begin
            state <= S_AIM;
            angle <= ANGLE_MID;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_CLEAR: begin
          if (timer == T_LAST) begin
            if (level == LAST_LVL) begin
              game_result <= 1'b1;
              state       <= S_OVER;
            end else begin
              level   <= level + 3'd1;
              period  <= period_for(level + 3'd1);
              load_ph <= 1'b0;
              state   <= S_LOAD;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed, self-checking bench for game_ctrl.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_game_ctrl;
  localparam int PC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  btn;
  logic        dead, win;
  logic [2:0]  state, angle, level;
  logic [19:0] period;
  logic [1:0]  lives;
  logic        game_result;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  game_ctrl #(
    .LIVES(3), .NUM_LEVELS(3), .PERIOD_BASE(1000), .PERIOD_STEP(100),
    .PAUSE_CYCLES(PC)
`ifdef GAME_CTRL_DEBOUNCE_EN
    , .DEB_CYCLES(8)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .btn_start(btn[0]), .btn_launch(btn[1]), .btn_aim_l(btn[2]), .btn_aim_r(btn[3]),
    .dead(dead), .win(win),
    .state(state), .angle(angle), .period(period), .level(level),
    .lives(lives), .game_result(game_result)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // one-cycle press, called on a falling edge
  task automatic press(input int b);
    btn[b] = 1'b1;
    @(negedge clk);
    btn[b] = 1'b0;
  endtask

  // press and wait until its action is visible
  task automatic act(input int b);
    press(b);
    tick(2);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_angle"}, int'(angle), 3);
    chk({tag, "_level"}, int'(level), 0);
    chk({tag, "_lives"}, int'(lives), 3);
    chk({tag, "_period"}, int'(period), 1000);
    chk({tag, "_result"}, int'(game_result), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    btn = '0; dead = 1'b0; win = 1'b0; rst = 1'b1;
    tick(2);
    chk_reset("rst");
    rst = 1'b0;
    tick(1);

`ifdef GAME_CTRL_DEBOUNCE_EN
    // 5-cycle glitch is shorter than the 8-cycle window
    btn[0] = 1'b1;
    tick(5);
    btn[0] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      chk("glitch_state", int'(state), 0);
    end
    // 12-cycle press: action 10 edges after the first edge that sees it
    btn[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (k == 10) chk("deb_before", int'(state), 0);
      if (k == 11) chk("deb_load", int'(state), 1);
    end
    btn[0] = 1'b0;
    tick(3);
    chk("deb_aim", int'(state), 2);
`else
    act(1);
    chk("idle_discard", int'(state), 0);

    press(0);
    tick(1);
    chk("start_lat", int'(state), 0);
    tick(1);
    chk("load1", int'(state), 1);
    chk("load_period", int'(period), 1000);
    chk("load_level", int'(level), 0);
    chk("load_lives", int'(lives), 3);
    tick(1);
    chk("load2", int'(state), 1);
    tick(1);
    chk("aim", int'(state), 2);
    chk("aim_angle", int'(angle), 3);

    for (int i = 0; i < 4; i++) begin
      act(3);
      chk("aim_r", int'(angle), (4 + i > 5) ? 5 : 4 + i);
    end
    for (int i = 0; i < 7; i++) begin
      act(2);
      chk("aim_l", int'(angle), (4 - i < 0) ? 0 : 4 - i);
    end
    act(3);
    chk("aim_r_from0", int'(angle), 1);
    btn[3:2] = 2'b11;
    tick(1);
    btn[3:2] = 2'b00;
    tick(2);
    chk("aim_both", int'(angle), 1);

    act(1);
    chk("run", int'(state), 3);
    act(3);
    chk("run_aim_discard", int'(angle), 1);

    for (int l = 3; l > 1; l--) begin
      dead = 1'b1;
      tick(1);
      dead = 1'b0;
      chk("lost_state", int'(state), 5);
      chk("lost_lives", int'(lives), l - 1);
      for (int k = 1; k < PC; k++) begin
        tick(1);
        chk("lost_dwell", int'(state), 5);
      end
      tick(1);
      chk("lost_exit", int'(state), 2);
      chk("lost_angle", int'(angle), 3);
      act(1);
      chk("rerun", int'(state), 3);
    end
    dead = 1'b1;
    tick(1);
    dead = 1'b0;
    chk("over_state", int'(state), 7);
    chk("over_lives", int'(lives), 0);
    chk("over_result", int'(game_result), 0);

    act(0);
    chk("restart", int'(state), 1);
    chk("restart_lives", int'(lives), 3);
    chk("restart_level", int'(level), 0);
    tick(2);
    chk("restart_aim", int'(state), 2);
    act(1);

    for (int lv = 0; lv < 2; lv++) begin
      win = 1'b1;
      dead = (lv == 0);
      tick(1);
      win = 1'b0;
      dead = 1'b0;
      chk("clear_state", int'(state), 6);
      chk("clear_lives", int'(lives), 3);
      for (int k = 1; k < PC; k++) begin
        tick(1);
        chk("clear_dwell", int'(state), 6);
      end
      tick(1);
      chk("next_load", int'(state), 1);
      chk("next_level", int'(level), lv + 1);
      chk("next_period", int'(period), 1000 - (lv + 1) * 100);
      tick(2);
      chk("next_aim", int'(state), 2);
      act(1);
    end
    win = 1'b1;
    tick(1);
    win = 1'b0;
    tick(PC);
    chk("win_over", int'(state), 7);
    chk("win_result", int'(game_result), 1);
    chk("win_level", int'(level), 2);

    act(0);
    tick(2);
    act(1);
    act(1);
    chk("pause", int'(state), 4);
    dead = 1'b1;
    win = 1'b1;
    tick(1);
    dead = 1'b0;
    win = 1'b0;
    tick(1);
    chk("pause_hold", int'(state), 4);
    chk("pause_lives", int'(lives), 3);
    act(1);
    chk("resume", int'(state), 3);
    act(1);
    chk("pause2", int'(state), 4);
    act(0);
    chk("abort", int'(state), 0);

    act(0);
    tick(2);
    act(3);
    chk("aim_again", int'(angle), 4);
    act(1);
    act(1);
    chk("pause3", int'(state), 4);
    rst = 1'b1;
    #1;
    chk_reset("async_rst");
    tick(1);
    rst = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Top-level game sequencer for the brick game; sits directly upstream of the ball/brick engine.
- Drives that engine's `state`, `angle`, `period` and `level` inputs, and consumes its `dead`/`win` flags.
- Turns raw pushbuttons into start, aim, launch and pause actions, and tracks lives and level progression.

Parameters:
LIVES, 3, lives at game start (1..3)
NUM_LEVELS, 3, number of levels; last level index is NUM_LEVELS-1 (max 8)
PERIOD_BASE, 200000, ball step period (clk cycles) at level 0
PERIOD_STEP, 40000, period reduction per level; PERIOD_BASE-(NUM_LEVELS-1)*PERIOD_STEP must be >= 16
PAUSE_CYCLES, 50000000, dwell time in LOST and CLEAR states
DEB_CYCLES, 500000, debounce stability window (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
btn_start  in  1  raw pushbutton: start game
btn_launch  in  1  raw pushbutton: launch in AIM, pause toggle in RUN/PAUSE
btn_aim_l  in  1  raw pushbutton: rotate aim left
btn_aim_r  in  1  raw pushbutton: rotate aim right
dead  in  1  ball lost, from ball engine (level, held)
win  in  1  all bricks cleared, from ball engine (level, held)
state  out  3  0 IDLE, 1 LOAD, 2 AIM, 3 RUN, 4 PAUSE, 5 LOST, 6 CLEAR, 7 OVER
angle  out  3  launch direction 0..5
period  out  20  ball step period for current level
level  out  3  current level index
lives  out  2  remaining lives
game_result  out  1  valid in OVER: 1 = all levels cleared, 0 = out of lives

Behaviour:
- Reset (async, rst=1): state=0, angle=3, level=0, lives=LIVES, period=PERIOD_BASE, game_result=0. All sync/edge/timer flops clear. Reset mid-game abandons it immediately.
- Buttons:
  - Each button passes a 2-flop synchronizer plus a previous-value flop.
  - Press event = sync output high AND previous-value low (one-cycle pulse per press; holding gives no repeat).
  - A press asserted before edge N changes outputs at edge N+2 (sync stages at N and N+1, action at N+2).
  - Events arriving in states that do not use them are discarded, not queued.
- IDLE(0):
  - start press -> LOAD; level=0, lives=LIVES, game_result=0.
- LOAD(1):
  - Held exactly 2 cycles, then -> AIM.
  - period = PERIOD_BASE - level*PERIOD_STEP is registered on entry (20-bit unsigned, no wrap given the parameter constraint).
- AIM(2):
  - angle is set to 3 on every entry.
  - aim_l press decrements angle, saturating at 0; aim_r press increments it, saturating at 5.
  - Simultaneous aim_l and aim_r: angle unchanged.
  - launch press -> RUN.
- RUN(3):
  - Priority: win, then dead, then launch.
  - win=1 -> CLEAR.
  - dead=1 and lives>1 -> lives-1, go to LOST.
  - dead=1 and lives==1 -> lives=0, game_result=0, go to OVER.
  - launch press -> PAUSE.
- PAUSE(4):
  - dead and win are ignored (the engine is frozen in this state).
  - launch press -> RUN.
  - start press -> IDLE (abort).
- LOST(5):
  - Timer counts PAUSE_CYCLES cycles, then -> AIM. Bricks are preserved because LOAD is not re-entered.
- CLEAR(6):
  - Timer counts PAUSE_CYCLES cycles.
  - If level == NUM_LEVELS-1: game_result=1, go to OVER.
  - Otherwise: level+1, go to LOAD.
- OVER(7):
  - Outputs held.
  - start press -> LOAD with level=0, lives=LIVES, game_result=0.
- Timer: free-running only in LOST/CLEAR; cleared on every state entry. Exit occurs on the cycle the timer reaches PAUSE_CYCLES-1.
- State encoding is fixed as listed; the ball engine decodes values 1, 2 and 3 directly.

Optional Feature:
- Macro: GAME_CTRL_DEBOUNCE_EN.
- Defined:
  - After synchronization, each button feeds a per-button counter.
  - The debounced level updates only after the synced input has differed from it for DEB_CYCLES consecutive cycles; any bounce resets that counter.
  - Edge detection uses the debounced level, so press latency = 2 + DEB_CYCLES cycles.
- Undefined: no debounce logic; DEB_CYCLES is unused and press latency is 2 cycles.

Test Plan:
- Bench parameters: PAUSE_CYCLES=4, NUM_LEVELS=3, PERIOD_BASE=1000, PERIOD_STEP=100.
- Reset then start press -> state 1 for exactly 2 cycles, then state 2; period=1000, level=0, lives=3, angle=3.
- In AIM: aim_r x4 -> angle 4, then 5, then stays 5; aim_l x7 -> angle ends at 0; aim_l and aim_r in the same cycle -> angle unchanged.
- RUN with dead=1, lives=3 -> lives=2, state 5 for 4 cycles, then state 2. Repeat twice more -> lives=0, state 7, game_result=0.
- RUN with win=1 at level 0 -> state 6 for 4 cycles, then state 1 with level=1, period=900. Win at level 2 -> state 7, game_result=1. dead=1 and win=1 together -> CLEAR taken, lives unchanged.
- RUN + launch -> state 4; dead pulse while in PAUSE -> no change; launch -> state 3. Assert rst mid-PAUSE -> all outputs at reset values immediately (asynchronous).
- With GAME_CTRL_DEBOUNCE_EN and DEB_CYCLES=8: a 5-cycle glitch on btn_start -> no transition; a 12-cycle press -> LOAD exactly 10 cycles after the rising edge.
